// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with word-memory FSM (RMW for sub-word stores).
// Optional macro LSU_MISALIGN_SPLIT_EN: serve misaligned accesses, splitting word-crossing ones.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_LO, WR_LO, RD_HI, WR_HI, RESP} state_t;
  state_t state, next_state;

  logic                  we_q, fault_q, cross_q, full_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, lo_q, hi_q, rdata_q;

  // Request decode, evaluated on the live request fields while idle
  logic [2:0] dec_size, dec_end;
  logic       dec_bad, dec_mis, dec_cross, dec_fault, dec_split, dec_full;

  always_comb begin
    dec_size = 3'd0;
    case (req_funct3[1:0])
      2'b00:   dec_size = 3'd1;
      2'b01:   dec_size = 3'd2;
      2'b10:   dec_size = 3'd4;
      default: dec_size = 3'd0;
    endcase
    dec_bad   = (&req_funct3[1:0]) | (req_funct3[2] & (req_we | req_funct3[1]));
    dec_end   = {1'b0, req_addr[1:0]} + dec_size;
    dec_mis   = ((dec_size == 3'd2) && req_addr[0]) ||
                ((dec_size == 3'd4) && (req_addr[1:0] != 2'b00));
    dec_cross = dec_end > 3'd4;
    dec_full  = (dec_size == 3'd4) && (req_addr[1:0] == 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
    dec_fault = dec_bad;
    dec_split = dec_cross & ~dec_bad;
`else
    dec_fault = dec_bad | dec_mis;
    dec_split = 1'b0;
`endif
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (dec_fault)                 next_state = RESP;
          else if (req_we && dec_full)   next_state = WR_LO;
          else                           next_state = RD_LO;
        end
      end
      RD_LO:   next_state = we_q ? WR_LO : (cross_q ? RD_HI : RESP);
      WR_LO:   next_state = cross_q ? RD_HI : RESP;
      RD_HI:   next_state = we_q ? WR_HI : RESP;
      WR_HI:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // 64-bit lane window so split accesses reuse the same shift/merge logic
  logic [4:0]              lane_shift;
  logic [2*DATA_WIDTH-1:0] size_mask, lane_mask, rd_win, rd_sh, wd_sh, merged;
  logic [DATA_WIDTH-1:0]   load_ext;

  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    case (f3_q[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      default: size_mask = 64'h0000_0000_FFFF_FFFF;
    endcase
    lane_mask = size_mask << lane_shift;
    rd_win    = (state == RD_HI) ? {mem_rdata, lo_q} : {{DATA_WIDTH{1'b0}}, mem_rdata};
    rd_sh     = rd_win >> lane_shift;
    wd_sh     = {{DATA_WIDTH{1'b0}}, wdata_q} << lane_shift;
    merged    = ({hi_q, lo_q} & ~lane_mask) | (wd_sh & lane_mask);
    case (f3_q)
      3'b000:  load_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b100:  load_ext = {24'd0, rd_sh[7:0]};
      3'b001:  load_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b101:  load_ext = {16'd0, rd_sh[15:0]};
      default: load_ext = rd_sh[DATA_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      cross_q <= 1'b0;
      full_q  <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        fault_q <= dec_fault;
        cross_q <= dec_split;
        full_q  <= dec_full;
      end
      if (state == RD_LO) lo_q <= mem_rdata;
      if (state == RD_HI) hi_q <= mem_rdata;
      if (next_state == RESP && state != RESP)
        rdata_q <= (!we_q && (state == RD_LO || state == RD_HI)) ? load_ext : '0;
    end
  end

  // A full aligned word store bypasses the merge so no stale read data leaks in
  always_comb begin
    mem_valid = !rst && (state == RD_LO || state == WR_LO || state == RD_HI || state == WR_HI);
    mem_we    = !rst && (state == WR_LO || state == WR_HI);
    mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    if (state == RD_HI || state == WR_HI) mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00} + 'd4;
    if (state == WR_HI)  mem_wdata = merged[2*DATA_WIDTH-1:DATA_WIDTH];
    else if (full_q)     mem_wdata = wdata_q;
    else                 mem_wdata = merged[DATA_WIDTH-1:0];
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_fault = (state == RESP) && fault_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:63];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_data;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_valid && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    else if (poke_en)        mem[poke_idx] <= poke_data;
  end

  int cycle = 0;
  int mv_cnt = 0;
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mem_valid) mv_cnt <= mv_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
    string       name;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_rdata"}, resp_rdata, e.rdata);
        check({e.name, "_fault"}, {31'd0, resp_fault}, {31'd0, e.fault});
        check({e.name, "_latency"}, 32'(cycle - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic poke(logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = a[7:2]; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic issue(string nm, logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                       logic [31:0] er, logic ef, int el);
    exp_t e;
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin
      check({nm, "_ready_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.rdata = er; e.fault = ef; e.lat = el; e.acc = cycle; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 20) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      check({nm, "_resp_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    int mv0;
    int t;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; poke_en = 1'b0; poke_idx = '0; poke_data = '0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    issue("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("sw_10_mem", mem[4], 32'hDEADBEEF);
    issue("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    poke(32'h10, 32'h11223344);
    issue("sb_13", 1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0, 3);
    check("sb_13_mem", mem[4], 32'h80223344);
    issue("lb_13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    issue("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
    issue("sh_12", 1'b1, 3'b001, 32'h12, 32'h1234BEEF, 32'h0, 1'b0, 3);
    check("sh_12_mem", mem[4], 32'hBEEF3344);

    poke(32'h20, 32'hCAFE1234);
    issue("lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFCAFE, 1'b0, 2);
    issue("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000CAFE, 1'b0, 2);
    mv0 = mv_cnt;
    issue("f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1);
    check("f3_011_no_mem", 32'(mv_cnt - mv0), 32'd0);
    mv0 = mv_cnt;
    issue("st_f3_100", 1'b1, 3'b100, 32'h20, 32'h55, 32'h0, 1'b1, 1);
    check("st_f3_100_no_mem", 32'(mv_cnt - mv0), 32'd0);
    check("st_f3_100_mem", mem[8], 32'hCAFE1234);

    poke(32'h0C, 32'h44332211);
    poke(32'h10, 32'h88776655);
`ifdef LSU_MISALIGN_SPLIT_EN
    issue("lw_0e", 1'b0, 3'b010, 32'h0E, 32'h0, 32'h66554433, 1'b0, 3);
    issue("lh_21", 1'b0, 3'b001, 32'h21, 32'h0, 32'hFFFFFE12, 1'b0, 2);
    issue("sw_0f", 1'b1, 3'b010, 32'h0F, 32'hAABBCCDD, 32'h0, 1'b0, 5);
    check("sw_0f_lo", mem[3], 32'hDD332211);
    check("sw_0f_hi", mem[4], 32'h88AABBCC);
`else
    mv0 = mv_cnt;
    issue("lw_0e", 1'b0, 3'b010, 32'h0E, 32'h0, 32'h0, 1'b1, 1);
    issue("lh_21", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 1);
    issue("sw_0f", 1'b1, 3'b010, 32'h0F, 32'hAABBCCDD, 32'h0, 1'b1, 1);
    check("misalign_no_mem", 32'(mv_cnt - mv0), 32'd0);
    check("sw_0f_lo", mem[3], 32'h44332211);
    check("sw_0f_hi", mem[4], 32'h88776655);
`endif

    // Reset landing on the write half of a read-modify-write
    poke(32'h10, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h10; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!mem_we && t < 10) begin @(negedge clk); t++; end
    check("rmw_reached_wr", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mem_we_forced", {31'd0, mem_we}, 32'd0);
    check("rst_mem_valid_forced", {31'd0, mem_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    check("rmw_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    repeat (4) @(negedge clk);
    check("rmw_rst_mem", mem[4], 32'h11223344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000001 expected 0x00000000");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters, one per line: DATA_WIDTH, XLEN (32), data word width, 32 is the only supported value; ADDR_WIDTH, XLEN (32), byte address width.
REQ-002 Ports (name, direction, width, meaning), clock and reset first: clk in 1 clock; rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-003 req_valid in 1 access request; req_ready out 1 unit can accept; req_we in 1 store=1/load=0; req_funct3 in 3 RV32I width code; req_addr in ADDR_WIDTH byte address; req_wdata in DATA_WIDTH store data.
REQ-004 resp_valid out 1 one-cycle completion pulse; resp_rdata out DATA_WIDTH load result; resp_fault out 1 access rejected (valid with resp_valid).
REQ-005 mem_valid out 1, mem_we out 1, mem_addr out ADDR_WIDTH, mem_wdata out DATA_WIDTH: drive the word-addressed data memory; mem_rdata in DATA_WIDTH is that memory's combinational same-cycle read; the memory writes at posedge when mem_valid&&mem_we.

Function
REQ-006 Request accepted at the posedge where req_valid&&req_ready; req_ready=1 only in IDLE; fields registered on acceptance, req_* ignored otherwise.
REQ-007 FSM states IDLE, RD_LO, WR_LO, RD_HI, WR_HI, RESP; one memory access per state; RESP lasts exactly one cycle with resp_valid=1, then IDLE.
REQ-008 Paths from IDLE: aligned LW/LH/LB: RD_LO->RESP; SW: WR_LO->RESP; SB/SH: RD_LO->WR_LO->RESP (read-modify-write); crossing load: RD_LO->RD_HI->RESP; crossing store: RD_LO->WR_LO->RD_HI->WR_HI->RESP; fault: directly to RESP.
REQ-009 Latency: resp_valid asserts N+1 cycles after acceptance, N = number of memory-access states on the path (fault: 1).
REQ-010 mem_valid=1 only in RD_*/WR_*; mem_we=1 only in WR_*; mem_addr = {addr[31:2],2'b00} in *_LO, that +4 (mod 2^32, wraps 0xFFFFFFFC->0x0) in *_HI.
REQ-011 WR_* writes the word captured in the preceding RD_* with only the target byte lanes replaced; SW aligned writes req_wdata whole; little-endian lanes.
REQ-012 funct3 000 LB / 100 LBU / 001 LH / 101 LHU sign/zero-extend; 010 LW; stores use 000/001/010; any other code -> fault, no memory access.
REQ-013 Misaligned = addr not multiple of access size; crossing = offset+size>4.
REQ-014 resp_rdata registered on entry to RESP, holds until next RESP; stores and faults load 0.
REQ-015 resp_fault=1 only during a RESP cycle of a faulting request, else 0.

Reset
REQ-016 rst high at a posedge: state->IDLE, resp_valid=0, resp_fault=0, resp_rdata=0, captured data cleared; req_ready=1 the cycle after.
REQ-017 mem_valid and mem_we are combinationally forced 0 while rst=1, so no write occurs in the reset cycle, including mid-RMW or mid-split; an interrupted request produces no response.

Configuration
REQ-018 Macro LSU_MISALIGN_SPLIT_EN defined: misaligned non-crossing accesses use the single-word path; crossing accesses use the split paths of REQ-008.
REQ-019 Macro undefined: every misaligned access faults (IDLE->RESP, no mem_valid); RD_HI/WR_HI are unreachable and may be omitted.

Verification
REQ-020 SW 0x10 0xDEADBEEF, then LW 0x10 -> resp_rdata=0xDEADBEEF, resp_fault=0; LW resp_valid 2 cycles after acceptance.
REQ-021 Word 0x10=0x11223344; SB 0x13 data 0x80 -> word 0x80223344 after 3 cycles; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
REQ-022 Word 0x20=0xCAFE1234; LH 0x22 -> 0xFFFFCAFE; LHU 0x22 -> 0x0000CAFE; funct3=011 -> resp_fault=1, resp_rdata=0, no mem_valid.
REQ-023 Words 0x0C=0x44332211, 0x10=0x88776655; LW 0x0E: with macro -> 0x66554433 at acceptance+3; without macro -> resp_fault=1 at acceptance+1.
REQ-024 With macro, SW 0x0F 0xAABBCCDD -> word 0x0C=0xDD332211, word 0x10=0x88AABBCC, resp_valid at acceptance+5.
REQ-025 SH 0x10 (word 0x11223344), rst high during WR_LO -> word unchanged, no resp_valid, req_ready=1 next cycle.
